// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core run controller and its halt detector.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } run_state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_PC      = 2'b01,
        HC_ZERO    = 2'b10,
        HC_TIMEOUT = 2'b11
    } halt_cause_t;

    // All-zero machine word decodes as AND R0,R0: a harmless no-op.
    localparam logic [8:0] ZERO_INSTR = 9'b0;

    // Zero-run counter is 4 bits wide and saturates at its maximum.
    localparam int ZR_CNT_W = 4;
    localparam logic [ZR_CNT_W-1:0] ZR_SAT = 4'd15;

endpackage

// File: rtl/core_run_controller_halt_detector.sv
// Halt detector: checks the current pc/mach_code/cycle count during RUN and
// reports whether the run must end and why. Owns the zero-run counter.
module halt_detector
    import core_ctrl_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter int              INSTR_W    = 9,
    parameter logic [PC_W-1:0] HALT_PC    = PC_W'(8'hFF),
    parameter int              ZERO_RUN   = 2,
    parameter int              CNT_W      = 16,
    parameter int unsigned     MAX_CYCLES = 60000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_en,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mach_code,
    input  logic [CNT_W-1:0]   cycle_count,
    output logic               halt,
    output logic [1:0]         cause
);

    logic [ZR_CNT_W-1:0] zr_cnt_q, zr_cnt_d;
    logic                is_zero;
    logic                pc_fire, zero_fire, to_fire;
    halt_cause_t         cause_c;

    assign is_zero = (mach_code == INSTR_W'(ZERO_INSTR));

    // Zero-run counter: counts consecutive zero words while running, cleared otherwise.
    always_comb begin
        zr_cnt_d = '0;
        if (run_en && is_zero) begin
            zr_cnt_d = (zr_cnt_q == ZR_SAT) ? ZR_SAT : zr_cnt_q + 1'b1;
        end
    end

    // Zero-run counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) zr_cnt_q <= '0;
        else          zr_cnt_q <= zr_cnt_d;
    end

    // Halt conditions with fixed priority: halt PC, then zero run, then timeout.
    always_comb begin
        pc_fire   = run_en && (pc == HALT_PC);
        zero_fire = run_en && is_zero &&
                    (({1'b0, zr_cnt_q} + 5'd1) >= 5'(ZERO_RUN));
        to_fire   = run_en && ((32'(cycle_count) + 32'd1) == 32'(MAX_CYCLES));
        cause_c   = HC_NONE;
        if (pc_fire)        cause_c = HC_PC;
        else if (zero_fire) cause_c = HC_ZERO;
        else if (to_fire)   cause_c = HC_TIMEOUT;
        halt  = pc_fire || zero_fire || to_fire;
        cause = cause_c;
    end

endmodule

// File: rtl/core_run_controller.sv
// Run sequencer for the 9-bit single-cycle core: start/done handshake, reset
// clearing window, execution enable, termination detection and run reporting.
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter int              INSTR_W      = 9,
    parameter logic [PC_W-1:0] HALT_PC      = PC_W'(8'hFF),
    parameter int              ZERO_RUN     = 2,
    parameter int              CLEAR_CYCLES = 2,
    parameter int              CNT_W        = 16,
    parameter int unsigned     MAX_CYCLES   = 60000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mach_code,
    output logic               core_reset,
    output logic               core_run,
    output logic               busy,
    output logic               done,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   cycle_count
);

    if (ZERO_RUN < 1 || ZERO_RUN > 15) begin : g_bad_zero_run
        $error("ZERO_RUN must be in 1..15");
    end
    if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_bad_clear
        $error("CLEAR_CYCLES must be in 1..15");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("CNT_W must be in 1..31");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > ((32'd1 << CNT_W) - 32'd1)) begin : g_bad_max
        $error("MAX_CYCLES must be in 1..2^CNT_W-1");
    end

    run_state_t       state_q, state_d;
    logic [3:0]       clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic             core_reset_q, core_reset_d;
    logic             core_run_q, core_run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             det_halt;
    logic [1:0]       det_cause;

    halt_detector #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .HALT_PC    (HALT_PC),
        .ZERO_RUN   (ZERO_RUN),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_halt_det (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_en      (state_q == RUN),
        .pc          (pc),
        .mach_code   (mach_code),
        .cycle_count (cycle_count_q),
        .halt        (det_halt),
        .cause       (det_cause)
    );

    // Next state, counters and registered outputs; outputs derive from the next
    // state so they change on the same edge as the state itself.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        cycle_count_d = cycle_count_q;
        halt_cause_d  = halt_cause_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = CLEAR;
                    clr_cnt_d     = 4'(CLEAR_CYCLES - 1);
                    cycle_count_d = '0;
                    halt_cause_d  = HC_NONE;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == '0) state_d = RUN;
                else                 clr_cnt_d = clr_cnt_q - 1'b1;
            end
            RUN: begin
                // The halting cycle still executes, so it is counted.
                cycle_count_d = cycle_count_q + 1'b1;
                if (det_halt) begin
                    state_d      = DONE;
                    halt_cause_d = det_cause;
                end
            end
            default: state_d = IDLE;
        endcase
        core_reset_d = (state_d == IDLE) || (state_d == CLEAR);
        core_run_d   = (state_d == RUN);
        busy_d       = (state_d == CLEAR) || (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            clr_cnt_q     <= '0;
            cycle_count_q <= '0;
            halt_cause_q  <= HC_NONE;
            core_reset_q  <= 1'b1;
            core_run_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            cycle_count_q <= cycle_count_d;
            halt_cause_q  <= halt_cause_d;
            core_reset_q  <= core_reset_d;
            core_run_q    <= core_run_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_run    = core_run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign halt_cause  = halt_cause_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: directed runs plus random
// programs, checked against a run-level scan of the termination rules.
module tb_core_run_controller;

    localparam int CLEAR_CYCLES = 2;
    localparam int ZERO_RUN     = 2;
    localparam int MAXC         = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] pc;
    logic [8:0] mach_code;
    logic       core_reset, core_run, busy, done;
    logic [1:0] halt_cause;
    logic [15:0] cycle_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] pcs [0:MAXC-1];
    logic [8:0] mcs [0:MAXC-1];

    always #5 clk = ~clk;

    core_run_controller #(
        .PC_W(8), .INSTR_W(9), .HALT_PC(8'hFF), .ZERO_RUN(ZERO_RUN),
        .CLEAR_CYCLES(CLEAR_CYCLES), .CNT_W(16), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pc(pc),
        .mach_code(mach_code), .core_reset(core_reset), .core_run(core_run),
        .busy(busy), .done(done), .halt_cause(halt_cause),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scan the program: first RUN index that ends the run, and why.
    task automatic predict(output int h, output logic [1:0] c);
        int zeros = 0;
        h = MAXC - 1;
        c = 2'b11;
        for (int i = 0; i < MAXC; i++) begin
            zeros = (mcs[i] == 9'd0) ? zeros + 1 : 0;
            if (pcs[i] == 8'hFF)                    begin h = i; c = 2'b01; return; end
            if (mcs[i] == 9'd0 && zeros >= ZERO_RUN) begin h = i; c = 2'b10; return; end
            if (i + 1 == MAXC)                      begin h = i; c = 2'b11; return; end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rst"},   core_reset, 1);
        chk({tag, "_run"},   core_run, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_cause"}, halt_cause, 0);
        chk({tag, "_cnt"},   cycle_count, 0);
    endtask

    // Called just after a negedge in IDLE or DONE. Runs pcs/mcs to termination.
    task automatic run_prog(input string name, input bit pulse_in_run);
        int         h;
        logic [1:0] c;
        predict(h, c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_start_busy"},  busy, 1);
        chk({name, "_start_done"},  done, 0);
        chk({name, "_start_cause"}, halt_cause, 0);
        chk({name, "_start_cnt"},   cycle_count, 0);
        chk({name, "_clr_rst"},     core_reset, 1);
        chk({name, "_clr_run"},     core_run, 0);
        for (int k = 1; k < CLEAR_CYCLES; k++) begin
            @(negedge clk);
            chk({name, "_clr_rst"},  core_reset, 1);
            chk({name, "_clr_run"},  core_run, 0);
            chk({name, "_clr_busy"}, busy, 1);
        end
        @(negedge clk);
        chk({name, "_run_rst"}, core_reset, 0);
        for (int i = 0; i <= h; i++) begin
            chk({name, "_run_on"},   core_run, 1);
            chk({name, "_run_busy"}, busy, 1);
            chk({name, "_run_done"}, done, 0);
            chk({name, "_run_cnt"},  cycle_count, i);
            pc        = pcs[i];
            mach_code = mcs[i];
            start     = (pulse_in_run && i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_end_done"},  done, 1);
        chk({name, "_end_cause"}, halt_cause, c);
        chk({name, "_end_cnt"},   cycle_count, h + 1);
        chk({name, "_end_run"},   core_run, 0);
        chk({name, "_end_rst"},   core_reset, 0);
        chk({name, "_end_busy"},  busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        pc        = 8'd0;
        mach_code = 9'd0;

        // Reset held three cycles, start ignored meanwhile.
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // PC halt on the 10th RUN cycle.
        for (int i = 0; i < MAXC; i++) begin
            pcs[i] = 8'(i);
            mcs[i] = 9'd1 + 9'(i);
        end
        pcs[9] = 8'hFF;
        run_prog("pchalt", 1'b0);

        // DONE holds its results while start is low.
        @(negedge clk);
        chk("hold_done",  done, 1);
        chk("hold_cause", halt_cause, 1);
        chk("hold_cnt",   cycle_count, 10);

        // Zero run: a lone zero does not halt, two in a row do.
        for (int i = 0; i < MAXC; i++) begin pcs[i] = 8'(i); mcs[i] = 9'h1A5; end
        mcs[1] = 9'd0; mcs[3] = 9'd0; mcs[4] = 9'd0;
        run_prog("zrun", 1'b1);

        // Timeout with no halt condition; start pulsed mid-run.
        for (int i = 0; i < MAXC; i++) begin pcs[i] = 8'(i); mcs[i] = 9'h0F0; end
        run_prog("tmo", 1'b1);

        // Halt PC and zero run fire together: halt PC wins.
        for (int i = 0; i < MAXC; i++) begin pcs[i] = 8'(i); mcs[i] = 9'h033; end
        mcs[0] = 9'd0; mcs[1] = 9'd0; pcs[1] = 8'hFF;
        run_prog("prio", 1'b0);

        // Randomized programs.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < MAXC; i++) begin
                pcs[i] = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                mcs[i] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_prog("rnd", 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CLEAR_CYCLES) @(negedge clk);
        pc = 8'd3; mach_code = 9'd7;
        repeat (5) @(negedge clk);
        chk("mid_cnt", cycle_count, 5);
        chk("mid_run", core_run, 1);
        #2;
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        check_reset_outputs("async");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_start");
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Run again from IDLE after the reset.
        for (int i = 0; i < MAXC; i++) begin pcs[i] = 8'(i); mcs[i] = 9'd5; end
        pcs[3] = 8'hFF;
        run_prog("again", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
